// File: rtl/alu_seq_mdu.sv
// Registered execute-stage ALU with an iterative shift-add multiplier and restoring divider.
// Operands and results move through valid/ready handshakes, so either side of the pipeline can stall.
module alu_seq_mdu #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    input  logic [3:0]            aluc_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] out_o,
    output logic                  carry_o,
    output logic                  zero_o,
    output logic                  ovf_o
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);

    typedef enum logic [3:0] {
        OP_ADD   = 4'h0, OP_SUB  = 4'h1, OP_AND  = 4'h2, OP_OR   = 4'h3,
        OP_XOR   = 4'h4, OP_LUI  = 4'h5, OP_SLL  = 4'h6, OP_SRL  = 4'h7,
        OP_SRA   = 4'h8, OP_MUL  = 4'h9, OP_MULHU = 4'hA, OP_DIVU = 4'hB,
        OP_REMU  = 4'hC
    } op_e;

    typedef enum logic {S_IDLE, S_BUSY} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    hi_q, hi_d, lo_q, lo_d, opb_q, opb_d;
    logic            div_q, div_d, high_q, high_d;
    logic [W-1:0]    out_q, out_d;
    logic            carry_q, carry_d, zero_q, zero_d, ovf_q, ovf_d, valid_q, valid_d;

    logic                   accept, is_iter, is_sub;
    logic [SHAMT_WIDTH-1:0] shamt;
    logic [W-1:0]           b_eff, sc_res;
    logic [W:0]             sum;
    logic                   sc_carry, sc_ovf;
    logic [W:0]             mul_sum, div_sh, div_diff;
    logic                   div_ge;
    logic [W-1:0]           step_hi, step_lo;

    assign in_ready_o = (state_q == S_IDLE) & (~valid_q | out_ready_i) & rst_ni;
    assign accept     = in_valid_i & in_ready_o;
    assign is_iter    = (aluc_i == OP_MUL) | (aluc_i == OP_MULHU) |
                        (aluc_i == OP_DIVU) | (aluc_i == OP_REMU);
    assign is_sub     = (aluc_i == OP_SUB);
    assign shamt      = b_i[SHAMT_WIDTH-1:0];

    // SUB reuses the adder as A + ~B + 1 so CARRY reads as "no borrow".
    assign b_eff = is_sub ? ~b_i : b_i;
    assign sum   = {1'b0, a_i} + {1'b0, b_eff} + {{W{1'b0}}, is_sub};

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
        sc_res   = '0;
        sc_carry = 1'b0;
        sc_ovf   = 1'b0;
        case (aluc_i)
            OP_ADD, OP_SUB: begin
                sc_res   = sum[W-1:0];
                sc_carry = sum[W];
                sc_ovf   = (a_i[W-1] == b_eff[W-1]) && (sum[W-1] != a_i[W-1]);
            end
            OP_AND:  sc_res = a_i & b_i;
            OP_OR:   sc_res = a_i | b_i;
            OP_XOR:  sc_res = a_i ^ b_i;
            OP_LUI:  sc_res = b_i << (W / 2);
            OP_SLL:  sc_res = a_i << shamt;
            OP_SRL:  sc_res = a_i >> shamt;
            OP_SRA:  sc_res = W'($signed(a_i) >>> shamt);
            default: sc_res = '0;
        endcase
    end

    // One iteration: {hi,lo} is product-high/multiplier or remainder/quotient.
    always_comb begin
        mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
        div_sh   = {hi_q, lo_q[W-1]};
        div_ge   = (div_sh >= {1'b0, opb_q});
        div_diff = div_sh - {1'b0, opb_q};
        if (div_q) begin
            step_hi = div_ge ? div_diff[W-1:0] : div_sh[W-1:0];
            step_lo = {lo_q[W-2:0], div_ge};
        end else begin
            step_hi = mul_sum[W:1];
            step_lo = {mul_sum[0], lo_q[W-1:1]};
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        opb_d   = opb_q;
        div_d   = div_q;
        high_d  = high_q;
        out_d   = out_q;
        carry_d = carry_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;
        valid_d = valid_q;

        if (valid_q && out_ready_i) begin
            out_d   = '0;
            carry_d = 1'b0;
            zero_d  = 1'b0;
            ovf_d   = 1'b0;
            valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (accept && is_iter) begin
                    state_d = S_BUSY;
                    cnt_d   = CW'(W - 1);
                    hi_d    = '0;
                    lo_d    = a_i;
                    opb_d   = b_i;
                    div_d   = (aluc_i == OP_DIVU) || (aluc_i == OP_REMU);
                    high_d  = (aluc_i == OP_MULHU) || (aluc_i == OP_REMU);
                end else if (accept) begin
                    out_d   = sc_res;
                    carry_d = sc_carry;
                    ovf_d   = sc_ovf;
                    zero_d  = (sc_res == '0);
                    valid_d = 1'b1;
                end
            end
            S_BUSY: begin
                hi_d = step_hi;
                lo_d = step_lo;
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                    out_d   = high_q ? step_hi : step_lo;
                    zero_d  = ((high_q ? step_hi : step_lo) == '0);
                    carry_d = 1'b0;
                    ovf_d   = 1'b0;
                    valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            opb_q   <= '0;
            div_q   <= 1'b0;
            high_q  <= 1'b0;
            out_q   <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            opb_q   <= opb_d;
            div_q   <= div_d;
            high_q  <= high_d;
            out_q   <= out_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
        end
    end

    assign out_valid_o = valid_q;
    assign out_o       = out_q;
    assign carry_o     = carry_q;
    assign zero_o      = zero_q;
    assign ovf_o       = ovf_q;

endmodule
